cla_serial_add_ctrl: RTL and testbench

CLA_SERIAL_ADD_CTRL -- requirements
Module: cla_serial_add_ctrl

---
 rtl/cla_pkg.sv | 13 +
 rtl/CLA_4bit.sv | 32 +++
 rtl/cla_serial_add_ctrl.sv | 136 +++++++++++++
 tb/tb_cla_serial_add_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the serial carry-lookahead adder controller:
// the controller state type and the width of one adder slice.
package cla_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/CLA_4bit.sv
// 4-bit carry-lookahead adder slice: every internal carry is formed
// directly from generate/propagate terms and the slice carry-in.
module CLA_4bit
  import cla_pkg::*;
(
  input  logic [NIB_W-1:0] a_i,
  input  logic [NIB_W-1:0] b_i,
  input  logic             c_i,
  output logic [NIB_W-1:0] s_o,
  output logic             c_o
);

  logic [NIB_W-1:0] g;
  logic [NIB_W-1:0] p;
  logic [NIB_W:0]   c;

  // Flat lookahead equations for all four carries and the sum bits.
  always_comb begin
    g    = a_i & b_i;
    p    = a_i ^ b_i;
    c[0] = c_i;
    c[1] = g[0] | (p[0] & c_i);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c_i);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c_i);
    s_o  = p ^ c[NIB_W-1:0];
    c_o  = c[NIB_W];
  end

endmodule

// File: rtl/cla_serial_add_ctrl.sv
// Nibble-serial adder controller: latches operands on a valid/ready
// accept, pushes one nibble per cycle through a single CLA_4bit slice,
// then holds the result (sum, carry-out, signed overflow) until taken.
// Optional macro CLA_SERIAL_SUB_EN adds a 'sub' input selecting a - b.
module cla_serial_add_ctrl
  import cla_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned NIB  = WIDTH / 4;
  localparam int unsigned IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIB - 1);
  localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic [IDXW-1:0]  idx_q;
  logic             carry_q, cout_q, ovf_q;
  logic             in_ready_q, out_valid_q, busy_q;

  logic [WIDTH-1:0] b_d;
  logic             carry_d;
  logic [NIB_W-1:0] a_nib, b_nib, s_nib;
  logic             c_nib;
  logic             ovf_d;

  // Effective second operand and nibble-0 carry captured at accept.
  always_comb begin
    b_d     = b;
    carry_d = cin;
`ifdef CLA_SERIAL_SUB_EN
    if (sub) begin
      b_d     = ~b;
      carry_d = 1'b1;
    end
`endif
  end

  // Current nibble operands and the signed-overflow verdict on the last nibble.
  always_comb begin
    a_nib = a_q[NIB_W*idx_q +: NIB_W];
    b_nib = b_q[NIB_W*idx_q +: NIB_W];
    ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (s_nib[NIB_W-1] != a_q[WIDTH-1]);
  end

  CLA_4bit u_slice (
    .a_i (a_nib),
    .b_i (b_nib),
    .c_i (carry_q),
    .s_o (s_nib),
    .c_o (c_nib)
  );

  // Controller FSM with registered handshake/status outputs and datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b_d;
            carry_q    <= carry_d;
            idx_q      <= '0;
            state_q    <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          sum_q[NIB_W*idx_q +: NIB_W] <= s_nib;
          carry_q                     <= c_nib;
          if (idx_q == IDX_LAST) begin
            state_q     <= DONE;
            cout_q      <= c_nib;
            ovf_q       <= ovf_d;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end else begin
            idx_q <= idx_q + IDX_ONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_serial_add_ctrl.sv
// Self-checking bench for cla_serial_add_ctrl (WIDTH = 32): directed
// vector table, backpressure / mid-run reset sequences, and a randomized
// handshake run against an arithmetic reference model.
module tb_cla_serial_add_ctrl;

  localparam int W   = 32;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready;
  logic [W-1:0] a, b;
  logic         cin;
`ifdef CLA_SERIAL_SUB_EN
  logic         sub;
`endif
  logic         out_valid, out_ready;
  logic [W-1:0] sum;
  logic         cout, ovf, busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cla_serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef CLA_SERIAL_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: {ovf, cout, sum} from plain W+1-bit arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mc, input logic ms);
    logic [W-1:0] be;
    logic         ci;
    logic [W:0]   t;
    logic         ov;
    be = ms ? ~mb : mb;
    ci = ms ? 1'b1 : mc;
    t  = {1'b0, ma} + {1'b0, be} + (W+1)'(ci);
    ov = (ma[W-1] == be[W-1]) && (t[W-1] != ma[W-1]);
    return {ov, t};
  endfunction

  task automatic set_sub(input logic v);
`ifdef CLA_SERIAL_SUB_EN
    sub = v;
`else
    if (v) $display("note: sub requested without subtract support");
`endif
  endtask

  // One complete operation starting from a negedge; returns result and
  // latency counted in edges, the accept edge being edge 1.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                        input logic ts, output logic [W-1:0] rs, output logic rc,
                        output logic ro, output int lat);
    int g;
    g = 0;
    lat = 0;
    rs = '0; rc = 1'b0; ro = 1'b0;
    while (in_ready !== 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (in_ready !== 1'b1) begin
      chk("ready_wait", 64'(in_ready), 64'(1));
      return;
    end
    a = ta; b = tb_; cin = tc; set_sub(ts);
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    lat = 1;
    #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); set_sub(1'b0);
    chk("busy_run", 64'(busy), 64'(1));
    while (out_valid !== 1'b1 && lat < 4 * NIB) begin
      @(posedge clk);
      lat++;
      #1;
    end
    rs = sum; rc = cout; ro = ovf;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic         s;
    logic [W-1:0] es;
    logic         ec;
    logic         eo;
  } vec_t;

  vec_t vt[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] rs, hs;
    logic         rc, ro, hc, ho;
    logic [W+1:0] m;
    logic [W+1:0] exp_q[$];
    int           lat, acc, cyc;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; set_sub(1'b0);

    vt.push_back('{32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0});
    vt.push_back('{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1});
    vt.push_back('{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0});
    vt.push_back('{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1});
    vt.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0});
    vt.push_back('{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0});
    vt.push_back('{32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0});
    vt.push_back('{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1});
`ifdef CLA_SERIAL_SUB_EN
    vt.push_back('{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0});
    vt.push_back('{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1});
`endif

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_sum", 64'(sum), 64'(0));
    chk("rst_cout", 64'(cout), 64'(0));
    chk("rst_ovf", 64'(ovf), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vector table
    foreach (vt[i]) begin
      run_op(vt[i].a, vt[i].b, vt[i].c, vt[i].s, rs, rc, ro, lat);
      chk($sformatf("vec%0d_sum", i), 64'(rs), 64'(vt[i].es));
      chk($sformatf("vec%0d_cout", i), 64'(rc), 64'(vt[i].ec));
      chk($sformatf("vec%0d_ovf", i), 64'(ro), 64'(vt[i].eo));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(NIB + 1));
    end

    // Backpressure: result held, in_ready low, exactly one accept afterwards
    a = 32'h0000_FFFF; b = 32'h0000_0001; cin = 1'b0; set_sub(1'b0);
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 4 * NIB) begin
      @(negedge clk);
      cyc++;
    end
    chk("bp_reached_done", 64'(out_valid), 64'(1));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1; a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
      chk("bp_hold_sum", 64'(sum), 64'(32'h0001_0000));
      chk("bp_hold_cout", 64'(cout), 64'(0));
      chk("bp_hold_ovf", 64'(ovf), 64'(0));
      chk("bp_hold_valid", 64'(out_valid), 64'(1));
      chk("bp_hold_ready", 64'(in_ready), 64'(0));
    end
    @(negedge clk);
    a = 32'd3; b = 32'd4; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    acc = 0;
    for (int k = 0; k < NIB; k++) begin
      if (k > 0) @(negedge clk);
      if (in_valid && in_ready) acc++;
      @(posedge clk);
      #1 out_ready = 1'b0;
    end
    chk("bp_single_accept", 64'(acc), 64'(1));
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 4 * NIB) begin
      @(negedge clk);
      cyc++;
    end
    chk("bp_next_sum", 64'(sum), 64'(7));
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);

    // Reset during RUN cycle 4 discards the pending result
    a = 32'h1111_1111; b = 32'h2222_2222; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mid_busy", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(in_ready), 64'(1));
    chk("mid_rst_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_sum", 64'(sum), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_valid", 64'(out_valid), 64'(0));
    @(negedge clk);
    run_op(32'h0123_4567, 32'h89AB_CDEF, 1'b1, 1'b0, rs, rc, ro, lat);
    m = model(32'h0123_4567, 32'h89AB_CDEF, 1'b1, 1'b0);
    chk("post_rst_sum", 64'(rs), 64'(m[W-1:0]));
    chk("post_rst_cout", 64'(rc), 64'(m[W]));

    // Randomized back-to-back operations with random handshakes
    acc = 0; cyc = 0;
    while ((acc < 1000 || exp_q.size() != 0) && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      in_valid = (acc < 1000) && ($urandom_range(0, 1) == 1);
      a = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
      cin = 1'($urandom_range(0, 1));
`ifdef CLA_SERIAL_SUB_EN
      sub = 1'($urandom_range(0, 1));
`endif
      out_ready = ($urandom_range(0, 3) != 0);
      if (in_valid && in_ready) begin
`ifdef CLA_SERIAL_SUB_EN
        exp_q.push_back(model(a, b, cin, sub));
`else
        exp_q.push_back(model(a, b, cin, 1'b0));
`endif
        acc++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("rnd_unexpected", 64'(1), 64'(0));
        end else begin
          m = exp_q.pop_front();
          hs = sum; hc = cout; ho = ovf;
          chk("rnd_sum", 64'(hs), 64'(m[W-1:0]));
          chk("rnd_cout", 64'(hc), 64'(m[W]));
          chk("rnd_ovf", 64'(ho), 64'(m[W+1]));
        end
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("rnd_accepts", 64'(acc), 64'(1000));
    chk("rnd_drained", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
